traffic_ctrl_n: RTL and testbench

Parametrised multi-approach traffic-light sequencer for the intersection controller. It serves `NUM_DIR` approaches in round-robin with green, yellow, left-turn, yellow and all-red clearance phases. Phase durations are held in runtime-writable BCD registers. The block adds a flashing-yellow night mode and phase skipping, and drives one lamp nibble per approach plus a shared two-digit BCD countdown display.

---
 rtl/traffic_pkg.sv | 38 +++
 rtl/traffic_ctrl_n_bcd_down2.sv | 35 +++
 rtl/traffic_ctrl_n.sv | 221 ++++++++++++++++++++++
 tb/tb_traffic_ctrl_n.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types, lamp codes and BCD helpers for the traffic sequencer.
// Latency: none, this file holds declarations only.
// Backpressure: none.
package traffic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GREEN,
    S_Y1,
    S_LEFT,
    S_Y2,
    S_CLR,
    S_FLASH
  } state_t;

  localparam logic [3:0] LAMP_RED  = 4'h8;
  localparam logic [3:0] LAMP_YEL  = 4'h4;
  localparam logic [3:0] LAMP_GRN  = 4'h2;
  localparam logic [3:0] LAMP_LEFT = 4'h1;
  localparam logic [3:0] LAMP_DARK = 4'h0;

  // Two-digit BCD decrement. A low digit of 0 borrows from the high digit.
  function automatic logic [7:0] bcd_dec2(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // True when both nibbles are legal decimal digits.
  function automatic logic bcd_valid(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Phases that cannot be skipped run for at least one second.
  function automatic logic [7:0] min_one(input logic [7:0] v);
    return (v == 8'h00) ? 8'h01 : v;
  endfunction

endpackage

// File: rtl/traffic_ctrl_n_bcd_down2.sv
// Two-digit BCD down-counter with synchronous load and decrement.
// Latency: 1 cycle from load/dec to cnt; is_one reflects the registered count.
// Backpressure: none; load wins over dec.
module bcd_down2
  import traffic_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [7:0] cnt,
  output logic       is_one
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: load has priority, otherwise step down in BCD.
  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = load_val;
    else if (dec) cnt_d = bcd_dec2(cnt_q);
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 8'h00;
    else     cnt_q <= cnt_d;
  end

  assign cnt    = cnt_q;
  assign is_one = (cnt_q == 8'h01);

endmodule

// File: rtl/traffic_ctrl_n.sv
// Round-robin multi-approach traffic-light sequencer with BCD phase timers and night flash.
// Latency: every output is registered, one cycle after the causing TICK/EN/NIGHT edge.
// Backpressure: none; TICK is counted on every cycle it is high.
module traffic_ctrl_n
  import traffic_pkg::*;
#(
  parameter int         NUM_DIR    = 2,
  parameter logic [7:0] DEF_GREEN  = 8'h40,
  parameter logic [7:0] DEF_LEFT   = 8'h15,
  parameter logic [7:0] DEF_YELLOW = 8'h05,
  parameter logic [7:0] DEF_CLR    = 8'h02
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              EN,
  input  logic                              TICK,
  input  logic                              NIGHT,
  input  logic                              CFG_WE,
  input  logic [$clog2(2*NUM_DIR+2)-1:0]    CFG_SEL,
  input  logic [7:0]                        CFG_DATA,
  output logic [4*NUM_DIR-1:0]              LAMP,
  output logic [7:0]                        COUNT,
  output logic [$clog2(NUM_DIR)-1:0]        ACTIVE_DIR
);

  localparam int SW = $clog2(2*NUM_DIR+2);
  localparam int DW = $clog2(NUM_DIR);

  state_t               state_q, state_d;
  logic [DW-1:0]        dir_q, dir_d;
  logic                 flash_q, flash_d;
  logic                 restart_q, restart_d;
  logic [4*NUM_DIR-1:0] lamp_q, lamp_d;
  logic [7:0]           green_q [NUM_DIR];
  logic [7:0]           green_d [NUM_DIR];
  logic [7:0]           left_q  [NUM_DIR];
  logic [7:0]           left_d  [NUM_DIR];
  logic [7:0]           yel_q, yel_d;
  logic [7:0]           clr_q, clr_d;

  logic                 cnt_ld, cnt_dec, cnt_is_one;
  logic [7:0]           cnt_ld_val;

  logic [DW-1:0]        dir_inc, nxt_dir;
  state_t               bd_state, ay_state;
  logic [DW-1:0]        bd_dir, ay_dir;
  logic [7:0]           bd_val, ay_val;

  // Duration registers: only fully valid BCD writes land.
  always_comb begin
    green_d = green_q;
    left_d  = left_q;
    yel_d   = yel_q;
    clr_d   = clr_q;
    if (CFG_WE && bcd_valid(CFG_DATA)) begin
      for (int d = 0; d < NUM_DIR; d++) begin
        if (CFG_SEL == SW'(d))           green_d[d] = CFG_DATA;
        if (CFG_SEL == SW'(NUM_DIR + d)) left_d[d]  = CFG_DATA;
      end
      if (CFG_SEL == SW'(2*NUM_DIR))     yel_d = CFG_DATA;
      if (CFG_SEL == SW'(2*NUM_DIR + 1)) clr_d = CFG_DATA;
    end
  end

  // Targets for the end of an approach (boundary) and for the end of its last yellow.
  always_comb begin
    dir_inc  = (dir_q == DW'(NUM_DIR - 1)) ? '0 : dir_q + DW'(1);
    nxt_dir  = restart_q ? '0 : dir_inc;
    bd_state = NIGHT ? S_FLASH : S_GREEN;
    bd_dir   = NIGHT ? '0 : nxt_dir;
    bd_val   = NIGHT ? 8'h00 : min_one(green_q[nxt_dir]);
    if (clr_q != 8'h00) begin
      ay_state = S_CLR;
      ay_dir   = dir_q;
      ay_val   = clr_q;
    end else begin
      ay_state = bd_state;
      ay_dir   = bd_dir;
      ay_val   = bd_val;
    end
  end

  // Phase sequencing and timer control.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    flash_d    = flash_q;
    restart_d  = restart_q;
    cnt_ld     = 1'b0;
    cnt_ld_val = 8'h00;
    cnt_dec    = 1'b0;
    if (!EN) begin
      state_d   = S_IDLE;
      dir_d     = '0;
      restart_d = 1'b0;
      cnt_ld    = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          dir_d  = '0;
          cnt_ld = 1'b1;
          if (NIGHT) state_d = S_FLASH;
          else begin
            state_d    = S_GREEN;
            cnt_ld_val = min_one(green_q[0]);
          end
        end
        S_GREEN, S_LEFT: if (TICK) begin
          if (cnt_is_one) begin
            state_d    = (state_q == S_GREEN) ? S_Y1 : S_Y2;
            cnt_ld     = 1'b1;
            cnt_ld_val = min_one(yel_q);
          end else cnt_dec = 1'b1;
        end
        S_Y1: if (TICK) begin
          if (!cnt_is_one) cnt_dec = 1'b1;
          else if (left_q[dir_q] != 8'h00) begin
            state_d    = S_LEFT;
            cnt_ld     = 1'b1;
            cnt_ld_val = left_q[dir_q];
          end else begin
            state_d    = ay_state;
            dir_d      = ay_dir;
            cnt_ld     = 1'b1;
            cnt_ld_val = ay_val;
          end
        end
        S_Y2: if (TICK) begin
          if (!cnt_is_one) cnt_dec = 1'b1;
          else begin
            state_d    = ay_state;
            dir_d      = ay_dir;
            cnt_ld     = 1'b1;
            cnt_ld_val = ay_val;
          end
        end
        S_CLR: if (TICK) begin
          if (!cnt_is_one) cnt_dec = 1'b1;
          else begin
            state_d    = bd_state;
            dir_d      = bd_dir;
            restart_d  = 1'b0;
            cnt_ld     = 1'b1;
            cnt_ld_val = bd_val;
          end
        end
        S_FLASH: begin
          if (!NIGHT) begin
            // Leaving night mode restarts the cycle at approach 0.
            dir_d  = '0;
            cnt_ld = 1'b1;
            if (clr_q != 8'h00) begin
              state_d    = S_CLR;
              restart_d  = 1'b1;
              cnt_ld_val = clr_q;
            end else begin
              state_d    = S_GREEN;
              cnt_ld_val = min_one(green_q[0]);
            end
          end else if (TICK) flash_d = ~flash_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Flash always opens with the lamps lit.
    if (state_d == S_FLASH && state_q != S_FLASH) flash_d = 1'b1;
  end

  // Lamp pattern for the state being entered, so LAMP is a plain register.
  always_comb begin
    lamp_d = {NUM_DIR{LAMP_RED}};
    for (int d = 0; d < NUM_DIR; d++) begin
      case (state_d)
        S_GREEN:    if (dir_d == DW'(d)) lamp_d[4*d +: 4] = LAMP_GRN;
        S_Y1, S_Y2: if (dir_d == DW'(d)) lamp_d[4*d +: 4] = LAMP_YEL;
        S_LEFT:     if (dir_d == DW'(d)) lamp_d[4*d +: 4] = LAMP_LEFT;
        S_FLASH:    lamp_d[4*d +: 4] = flash_d ? LAMP_YEL : LAMP_DARK;
        default:    ;
      endcase
    end
  end

  // State, lamp and duration registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      dir_q     <= '0;
      flash_q   <= 1'b0;
      restart_q <= 1'b0;
      lamp_q    <= {NUM_DIR{LAMP_RED}};
      green_q   <= '{default: DEF_GREEN};
      left_q    <= '{default: DEF_LEFT};
      yel_q     <= DEF_YELLOW;
      clr_q     <= DEF_CLR;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      flash_q   <= flash_d;
      restart_q <= restart_d;
      lamp_q    <= lamp_d;
      green_q   <= green_d;
      left_q    <= left_d;
      yel_q     <= yel_d;
      clr_q     <= clr_d;
    end
  end

  bcd_down2 u_count (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_ld),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec),
    .cnt      (COUNT),
    .is_one   (cnt_is_one)
  );

  assign LAMP       = lamp_q;
  assign ACTIVE_DIR = dir_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Directed bench for traffic_ctrl_n: two-approach and four-approach instances.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Every wait is a fixed cycle count, with a watchdog as a backstop.
module tb_traffic_ctrl_n;

  logic       clk = 1'b0;
  logic       rst, en, tick, night, cfg_we;
  logic [2:0] cfg_sel;
  logic [7:0] cfg_data;
  logic [7:0] lamp, count;
  logic [0:0] adir;

  logic        en4, cfg_we4;
  logic [3:0]  cfg_sel4;
  logic [7:0]  cfg_data4;
  logic [15:0] lamp4;
  logic [7:0]  count4;
  logic [1:0]  adir4;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  traffic_ctrl_n #(.NUM_DIR(2)) dut (
    .CLK(clk), .RST(rst), .EN(en), .TICK(tick), .NIGHT(night),
    .CFG_WE(cfg_we), .CFG_SEL(cfg_sel), .CFG_DATA(cfg_data),
    .LAMP(lamp), .COUNT(count), .ACTIVE_DIR(adir)
  );

  traffic_ctrl_n #(.NUM_DIR(4)) dut4 (
    .CLK(clk), .RST(rst), .EN(en4), .TICK(tick), .NIGHT(night),
    .CFG_WE(cfg_we4), .CFG_SEL(cfg_sel4), .CFG_DATA(cfg_data4),
    .LAMP(lamp4), .COUNT(count4), .ACTIVE_DIR(adir4)
  );

  task automatic do_tick(input int n);
    repeat (n) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  task automatic wr(input logic [2:0] sel, input logic [7:0] dat);
    @(negedge clk) begin cfg_we = 1'b1; cfg_sel = sel; cfg_data = dat; end
    @(negedge clk) cfg_we = 1'b0;
  endtask

  task automatic wr4(input logic [3:0] sel, input logic [7:0] dat);
    @(negedge clk) begin cfg_we4 = 1'b1; cfg_sel4 = sel; cfg_data4 = dat; end
    @(negedge clk) cfg_we4 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; en4 = 1'b0; tick = 1'b0; night = 1'b0;
    cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0;
    cfg_we4 = 1'b0; cfg_sel4 = '0; cfg_data4 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_run++; if (lamp !== 8'h88) begin n_fail++; $display("FAIL reset_lamp: got %h want 88", lamp); end
    n_run++; if (count !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", count); end
    n_run++; if (adir !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %0d want 0", adir); end
    n_run++; if (lamp4 !== 16'h8888) begin n_fail++; $display("FAIL reset_lamp4: got %h want 8888", lamp4); end
    do_tick(10);
    n_run++; if (lamp !== 8'h88) begin n_fail++; $display("FAIL idle_lamp: got %h want 88", lamp); end
    n_run++; if (count !== 8'h00) begin n_fail++; $display("FAIL idle_count: got %h want 00", count); end
    n_run++; if (adir !== 1'b0) begin n_fail++; $display("FAIL idle_dir: got %0d want 0", adir); end
  endtask

  // All phases 1 s, left and clearance skipped: 2 ticks per approach.
  task automatic test_four_dir;
    logic [15:0] exp_g, exp_y;
    for (int s = 0; s < 4; s++) begin
      wr4(4'(s), 8'h00);
      wr4(4'(4 + s), 8'h00);
    end
    wr4(4'd8, 8'h00);
    wr4(4'd9, 8'h00);
    @(negedge clk) en4 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      for (int d = 0; d < 4; d++) begin
        exp_g[4*d +: 4] = (d == i % 4) ? 4'h2 : 4'h8;
        exp_y[4*d +: 4] = (d == i % 4) ? 4'h4 : 4'h8;
      end
      n_run++; if (adir4 !== 2'(i % 4)) begin n_fail++; $display("FAIL four_dir[%0d]: got %0d want %0d", i, adir4, i % 4); end
      n_run++; if (lamp4 !== exp_g) begin n_fail++; $display("FAIL four_green[%0d]: got %h want %h", i, lamp4, exp_g); end
      n_run++; if (count4 !== 8'h01) begin n_fail++; $display("FAIL four_count[%0d]: got %h want 01", i, count4); end
      do_tick(1);
      n_run++; if (lamp4 !== exp_y) begin n_fail++; $display("FAIL four_yel[%0d]: got %h want %h", i, lamp4, exp_y); end
      n_run++; if (count4 !== 8'h01) begin n_fail++; $display("FAIL four_ycount[%0d]: got %h want 01", i, count4); end
      do_tick(1);
    end
    @(negedge clk) en4 = 1'b0;
    @(negedge clk);
    n_run++; if (lamp4 !== 16'h8888) begin n_fail++; $display("FAIL four_off: got %h want 8888", lamp4); end
  endtask

  task automatic test_default_seq;
    @(negedge clk) en = 1'b1;
    @(negedge clk);
    n_run++; if (lamp !== 8'h82) begin n_fail++; $display("FAIL g0_lamp: got %h want 82", lamp); end
    n_run++; if (count !== 8'h40) begin n_fail++; $display("FAIL g0_count: got %h want 40", count); end
    do_tick(30);
    n_run++; if (count !== 8'h10) begin n_fail++; $display("FAIL g0_10: got %h want 10", count); end
    do_tick(1);
    n_run++; if (count !== 8'h09) begin n_fail++; $display("FAIL g0_09: got %h want 09", count); end
    do_tick(8);
    n_run++; if (count !== 8'h01 || lamp !== 8'h82) begin n_fail++; $display("FAIL g0_last: got %h/%h want 01/82", count, lamp); end
    do_tick(1);
    n_run++; if (count !== 8'h05 || lamp !== 8'h84) begin n_fail++; $display("FAIL y1_0: got %h/%h want 05/84", count, lamp); end
    do_tick(5);
    n_run++; if (count !== 8'h15 || lamp !== 8'h81) begin n_fail++; $display("FAIL left_0: got %h/%h want 15/81", count, lamp); end
    do_tick(15);
    n_run++; if (count !== 8'h05 || lamp !== 8'h84) begin n_fail++; $display("FAIL y2_0: got %h/%h want 05/84", count, lamp); end
    do_tick(5);
    n_run++; if (count !== 8'h02 || lamp !== 8'h88 || adir !== 1'b0) begin n_fail++; $display("FAIL clr_0: got %h/%h/%0d want 02/88/0", count, lamp, adir); end
    do_tick(2);
    n_run++; if (count !== 8'h40 || lamp !== 8'h28 || adir !== 1'b1) begin n_fail++; $display("FAIL g1: got %h/%h/%0d want 40/28/1", count, lamp, adir); end
  endtask

  // Approach 1 is in green; left[1] and clr are loaded later, so the writes apply.
  task automatic test_skip;
    wr(3'd3, 8'h00);
    wr(3'd5, 8'h00);
    n_run++; if (count !== 8'h40 || lamp !== 8'h28) begin n_fail++; $display("FAIL skip_hold: got %h/%h want 40/28", count, lamp); end
    do_tick(40);
    n_run++; if (count !== 8'h05 || lamp !== 8'h48) begin n_fail++; $display("FAIL skip_y1: got %h/%h want 05/48", count, lamp); end
    do_tick(5);
    n_run++; if (count !== 8'h40 || lamp !== 8'h82 || adir !== 1'b0) begin n_fail++; $display("FAIL skip_g0: got %h/%h/%0d want 40/82/0", count, lamp, adir); end
  endtask

  task automatic test_night;
    wr(3'd5, 8'h02);
    @(negedge clk) night = 1'b1;
    do_tick(1);
    n_run++; if (count !== 8'h39 || lamp !== 8'h82) begin n_fail++; $display("FAIL night_green: got %h/%h want 39/82", count, lamp); end
    do_tick(39 + 5 + 15 + 5);
    n_run++; if (count !== 8'h02 || lamp !== 8'h88) begin n_fail++; $display("FAIL night_clr: got %h/%h want 02/88", count, lamp); end
    do_tick(1);
    n_run++; if (lamp !== 8'h88) begin n_fail++; $display("FAIL night_clr1: got %h want 88", lamp); end
    do_tick(1);
    n_run++; if (lamp !== 8'h44 || count !== 8'h00) begin n_fail++; $display("FAIL flash_on: got %h/%h want 44/00", lamp, count); end
    do_tick(1);
    n_run++; if (lamp !== 8'h00) begin n_fail++; $display("FAIL flash_off: got %h want 00", lamp); end
    do_tick(1);
    n_run++; if (lamp !== 8'h44) begin n_fail++; $display("FAIL flash_on2: got %h want 44", lamp); end
    @(negedge clk) night = 1'b0;
    @(negedge clk);
    n_run++; if (lamp !== 8'h88 || count !== 8'h02 || adir !== 1'b0) begin n_fail++; $display("FAIL unflash_clr: got %h/%h/%0d want 88/02/0", lamp, count, adir); end
    do_tick(2);
    n_run++; if (lamp !== 8'h82 || count !== 8'h40 || adir !== 1'b0) begin n_fail++; $display("FAIL unflash_g0: got %h/%h/%0d want 82/40/0", lamp, count, adir); end
  endtask

  task automatic test_en_drop;
    do_tick(40 + 5 + 8);
    n_run++; if (lamp !== 8'h81 || count !== 8'h07) begin n_fail++; $display("FAIL left_07: got %h/%h want 81/07", lamp, count); end
    @(negedge clk) begin en = 1'b0; cfg_we = 1'b1; cfg_sel = 3'd0; cfg_data = 8'h3A; end
    @(negedge clk) cfg_we = 1'b0;
    n_run++; if (lamp !== 8'h88 || count !== 8'h00 || adir !== 1'b0) begin n_fail++; $display("FAIL en_drop: got %h/%h/%0d want 88/00/0", lamp, count, adir); end
    @(negedge clk) en = 1'b1;
    @(negedge clk);
    n_run++; if (lamp !== 8'h82 || count !== 8'h40) begin n_fail++; $display("FAIL bad_write: got %h/%h want 82/40", lamp, count); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_four_dir();
    test_default_seq();
    test_skip();
    test_night();
    test_en_drop();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
